loop_gain_demod: RTL

- Digital back end for the loop-gain stability bench; sits directly downstream of the broken-loop amplifier stage.
- Consumes synchronously sampled voltages from the two injection-source nodes, "input" (loop input) and "output" (loop return), taken at exactly 4x the injection frequency.
- Performs quadrature (I/Q) demodulation and accumulation on each channel, then reports per-channel I/Q, magnitude estimates, a gain ≥ 1 flag and a coarse loop-phase quadrant.
- Ratio and phase refinement are left to downstream firmware.

---
 rtl/loop_gain_demod.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/loop_gain_demod.sv
// loop_gain_demod
//   Quadrature demodulator for the loop-gain stability bench. Both node
//   samples arrive at 4x the injection frequency. Each channel is mixed with
//   the 4-phase I/Q references and accumulated over 2^LOG2_N injection
//   periods. The block then reports I/Q, magnitude estimates, a gain >= 1
//   flag and the coarse loop-phase quadrant.
//
// Ports
//   clk, rst            sample clock, asynchronous active-high reset
//   start               request a measurement (taken only while not busy)
//   in_valid            in_sample / out_sample valid this cycle
//   in_sample           signed loop-input node sample
//   out_sample          signed loop-output node sample
//   busy                measurement in progress (SETTLE, ACCUM, CALC)
//   done                one-cycle pulse, results valid
//   i_in, q_in          signed demodulated loop-input I/Q
//   i_out, q_out        signed demodulated loop-output I/Q
//   mag_in, mag_out     unsigned magnitude estimates
//   gain_ge_one         mag_out >= mag_in
//   phase_quad          quadrant of the output vector relative to the input vector
module loop_gain_demod #(
  parameter  int DATA_W = 12,
  parameter  int LOG2_N = 8,
  parameter  int SETTLE = 64,
  localparam int ACC_W  = DATA_W + LOG2_N + 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_sample,
  input  logic signed [DATA_W-1:0] out_sample,
  output logic                     busy,
  output logic                     done,
  output logic signed [ACC_W-1:0]  i_in,
  output logic signed [ACC_W-1:0]  q_in,
  output logic signed [ACC_W-1:0]  i_out,
  output logic signed [ACC_W-1:0]  q_out,
  output logic        [ACC_W-1:0]  mag_in,
  output logic        [ACC_W-1:0]  mag_out,
  output logic                     gain_ge_one,
  output logic        [1:0]        phase_quad
);

  localparam int CNT_W = LOG2_N + 2;
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SET_LAST = (SETTLE > 0) ? SET_W'(SETTLE - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_ACCUM  = 3'd2,
    S_CALC   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // |v|; the most negative code cannot occur because the accumulator has headroom.
  function automatic logic [ACC_W-1:0] f_abs(input logic signed [ACC_W-1:0] v);
    f_abs = v[ACC_W-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  // max(|i|,|q|) + floor(min(|i|,|q|)/2)
  function automatic logic [ACC_W-1:0] f_mag(input logic signed [ACC_W-1:0] i_v,
                                             input logic signed [ACC_W-1:0] q_v);
    logic [ACC_W-1:0] a_v;
    logic [ACC_W-1:0] b_v;
    a_v = f_abs(i_v);
    b_v = f_abs(q_v);
    if (a_v >= b_v) f_mag = a_v + {1'b0, b_v[ACC_W-1:1]};
    else            f_mag = b_v + {1'b0, a_v[ACC_W-1:1]};
  endfunction

  // Quadrant 0..3 counter-clockwise: {Q<0, I<0 xor Q<0} yields 0,1,2,3 directly.
  function automatic logic [1:0] f_quad(input logic signed [ACC_W-1:0] i_v,
                                        input logic signed [ACC_W-1:0] q_v);
    f_quad = {q_v[ACC_W-1], i_v[ACC_W-1] ^ q_v[ACC_W-1]};
  endfunction

  state_t                    r_state;
  state_t                    w_next;
  state_t                    w_first;
  logic                      w_accept;
  logic [SET_W-1:0]          r_set_cnt;
  logic [CNT_W-1:0]          r_cnt;
  logic signed [ACC_W-1:0]   r_acc_i_in, r_acc_q_in, r_acc_i_out, r_acc_q_out;
  logic signed [ACC_W-1:0]   w_in_ext, w_out_ext;
  logic [ACC_W-1:0]          w_mag_in, w_mag_out;
  logic [1:0]                w_quad_in, w_quad_out;
  logic                      r_busy, r_done, r_gge;
  logic signed [ACC_W-1:0]   r_i_in, r_q_in, r_i_out, r_q_out;
  logic [ACC_W-1:0]          r_mag_in, r_mag_out;
  logic [1:0]                r_phase;

  assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_first   = (SETTLE == 0) ? S_ACCUM : S_SETTLE;
  assign w_in_ext  = {{(ACC_W-DATA_W){in_sample[DATA_W-1]}}, in_sample};
  assign w_out_ext = {{(ACC_W-DATA_W){out_sample[DATA_W-1]}}, out_sample};
  assign w_mag_in   = f_mag(r_acc_i_in, r_acc_q_in);
  assign w_mag_out  = f_mag(r_acc_i_out, r_acc_q_out);
  assign w_quad_in  = f_quad(r_acc_i_in, r_acc_q_in);
  assign w_quad_out = f_quad(r_acc_i_out, r_acc_q_out);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_first;
        else          w_next = S_IDLE;
      end
      S_SETTLE: begin
        if (in_valid && (r_set_cnt == SET_LAST)) w_next = S_ACCUM;
        else                                     w_next = S_SETTLE;
      end
      S_ACCUM: begin
        if (in_valid && (r_cnt == CNT_LAST)) w_next = S_CALC;
        else                                 w_next = S_ACCUM;
      end
      S_CALC:  w_next = S_DONE;
      S_DONE: begin
        if (w_accept) w_next = w_first;
        else          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Counters and I/Q accumulators; only valid samples advance them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_set_cnt   <= '0;
      r_cnt       <= '0;
      r_acc_i_in  <= '0;
      r_acc_q_in  <= '0;
      r_acc_i_out <= '0;
      r_acc_q_out <= '0;
    end else if (w_accept) begin
      r_set_cnt   <= '0;
      r_cnt       <= '0;
      r_acc_i_in  <= '0;
      r_acc_q_in  <= '0;
      r_acc_i_out <= '0;
      r_acc_q_out <= '0;
    end else begin
      if ((r_state == S_SETTLE) && in_valid) begin
        r_set_cnt <= r_set_cnt + SET_W'(1);
      end
      if ((r_state == S_ACCUM) && in_valid) begin
        r_cnt <= r_cnt + CNT_W'(1);
        // phase p = r_cnt mod 4: I ref +1,0,-1,0 ; Q ref 0,-1,0,+1
        case (r_cnt[1:0])
          2'd0: begin
            r_acc_i_in  <= r_acc_i_in  + w_in_ext;
            r_acc_i_out <= r_acc_i_out + w_out_ext;
          end
          2'd1: begin
            r_acc_q_in  <= r_acc_q_in  - w_in_ext;
            r_acc_q_out <= r_acc_q_out - w_out_ext;
          end
          2'd2: begin
            r_acc_i_in  <= r_acc_i_in  - w_in_ext;
            r_acc_i_out <= r_acc_i_out - w_out_ext;
          end
          2'd3: begin
            r_acc_q_in  <= r_acc_q_in  + w_in_ext;
            r_acc_q_out <= r_acc_q_out + w_out_ext;
          end
          default: begin
            r_acc_i_in  <= r_acc_i_in;
          end
        endcase
      end
    end
  end

  // Status flags, registered from the next state so they line up with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next == S_SETTLE) || (w_next == S_ACCUM) || (w_next == S_CALC);
      r_done <= (w_next == S_DONE);
    end
  end

  // Result registers, loaded on the edge leaving CALC and held until the next one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i_in    <= '0;
      r_q_in    <= '0;
      r_i_out   <= '0;
      r_q_out   <= '0;
      r_mag_in  <= '0;
      r_mag_out <= '0;
      r_gge     <= 1'b0;
      r_phase   <= 2'd0;
    end else if (r_state == S_CALC) begin
      r_i_in    <= r_acc_i_in;
      r_q_in    <= r_acc_q_in;
      r_i_out   <= r_acc_i_out;
      r_q_out   <= r_acc_q_out;
      r_mag_in  <= w_mag_in;
      r_mag_out <= w_mag_out;
      r_gge     <= (w_mag_out >= w_mag_in);
      r_phase   <= w_quad_out - w_quad_in;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign i_in        = r_i_in;
  assign q_in        = r_q_in;
  assign i_out       = r_i_out;
  assign q_out       = r_q_out;
  assign mag_in      = r_mag_in;
  assign mag_out     = r_mag_out;
  assign gain_ge_one = r_gge;
  assign phase_quad  = r_phase;

endmodule
